// File: rtl/id_operand_stage.sv
// Decode-side operand stage: EX/MEM forwarding into RF operands, load-use stall FSM,
// valid/ready ID/EX pipeline register and a saturating stall-cycle counter.
module id_operand_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic              in_uses_rs,
  input  logic              in_uses_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_wr_addr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              stall_active,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A load in EX has no result yet, so it is never a forwarding source.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [ADDR_W-1:0] src,
    input logic [DATA_W-1:0] rf_val,
    input logic              ex_en,
    input logic [ADDR_W-1:0] ex_addr,
    input logic [DATA_W-1:0] ex_val,
    input logic              mem_en,
    input logic [ADDR_W-1:0] mem_addr,
    input logic [DATA_W-1:0] mem_val
  );
    logic [DATA_W-1:0] sel;
    if (ex_en && (ex_addr == src)) begin
      sel = ex_val;
    end else if (mem_en && (mem_addr == src)) begin
      sel = mem_val;
    end else begin
      sel = rf_val;
    end
    return sel;
  endfunction

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              hazard_s, adv_s, ready_s, xfer_s, ex_fwd_en_s;
  logic [DATA_W-1:0] fwd_a_s, fwd_b_s;

  // Hazard detection, handshake and forwarded operand selection
  always_comb begin
    ex_fwd_en_s = ex_wr_en & ~ex_is_load;
    hazard_s    = in_valid & ex_wr_en & ex_is_load
                & ((in_uses_rs & (ex_wr_addr == in_rs)) | (in_uses_rt & (ex_wr_addr == in_rt)));
    adv_s       = ~valid_q | out_ready;
    ready_s     = adv_s & ~hazard_s & ~flush;
    xfer_s      = in_valid & ready_s;
    fwd_a_s     = fwd_sel(in_rs, rf_data1, ex_fwd_en_s, ex_wr_addr, ex_result,
                          mem_wr_en, mem_wr_addr, mem_result);
    fwd_b_s     = fwd_sel(in_rt, rf_data2, ex_fwd_en_s, ex_wr_addr, ex_result,
                          mem_wr_en, mem_wr_addr, mem_result);
  end

  // ID/EX register next state: flush beats transfer; data holds on bubble and backpressure
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (xfer_s) begin
      valid_d = 1'b1;
      a_d     = fwd_a_s;
      b_d     = fwd_b_s;
      imm_d   = in_imm;
      rd_d    = in_rd;
      ctrl_d  = in_ctrl;
    end else if (adv_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Stall FSM next state and saturating stall counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN:   state_d = (hazard_s && !flush) ? ST_STALL : ST_RUN;
      ST_STALL: state_d = (!hazard_s || flush) ? ST_RUN : ST_STALL;
      default:  state_d = ST_RUN;
    endcase
    if ((state_q == ST_STALL) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, pipeline and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      a_q     <= {DATA_W{1'b0}};
      b_q     <= {DATA_W{1'b0}};
      imm_q   <= {DATA_W{1'b0}};
      rd_q    <= {ADDR_W{1'b0}};
      ctrl_q  <= {CTRL_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready     = ready_s;
  assign rf_addr1     = in_rs;
  assign rf_addr2     = in_rt;
  assign out_valid    = valid_q;
  assign out_a        = a_q;
  assign out_b        = b_q;
  assign out_imm      = imm_q;
  assign out_rd       = rd_q;
  assign out_ctrl     = ctrl_q;
  assign stall_active = (state_q == ST_STALL);
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: transaction-level reference model plus
// directed literal checks; a narrow-counter second instance exercises saturation.
module tb_id_operand_stage;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int CW = 8;
  localparam int NW = 16;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid, in_uses_rs, in_uses_rt;
  logic [AW-1:0] in_rs, in_rt, in_rd;
  logic [DW-1:0] in_imm;
  logic [CW-1:0] in_ctrl;
  logic          ex_wr_en, ex_is_load, mem_wr_en, flush, out_ready;
  logic [AW-1:0] ex_wr_addr, mem_wr_addr;
  logic [DW-1:0] ex_result, mem_result;
  logic [DW-1:0] regs [4];

  logic          in_ready, out_valid, stall_active;
  logic [AW-1:0] rf_addr1, rf_addr2, out_rd;
  logic [DW-1:0] rf_data1, rf_data2, out_a, out_b, out_imm;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] stall_cnt;

  logic          s_in_ready, s_out_valid, s_stall_active;
  logic [AW-1:0] s_rf_addr1, s_rf_addr2, s_out_rd;
  logic [DW-1:0] s_out_a, s_out_b, s_out_imm;
  logic [CW-1:0] s_out_ctrl;
  logic [SW-1:0] s_stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit          m_valid, m_stall;
  int          m_cnt;
  logic [DW-1:0] m_a, m_b, m_imm;
  logic [AW-1:0] m_rd;
  logic [CW-1:0] m_ctrl;

  always #5 clk = ~clk;

  assign rf_data1 = regs[rf_addr1];
  assign rf_data2 = regs[rf_addr2];

  id_operand_stage #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_result(mem_result),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .stall_active(stall_active), .stall_cnt(stall_cnt)
  );

  id_operand_stage #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .CNT_W(SW)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_addr1(s_rf_addr1), .rf_addr2(s_rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_result(mem_result),
    .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_a(s_out_a), .out_b(s_out_b), .out_imm(s_out_imm), .out_rd(s_out_rd), .out_ctrl(s_out_ctrl),
    .stall_active(s_stall_active), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] operand(input logic [AW-1:0] src);
    if (ex_wr_en && !ex_is_load && ex_wr_addr == src) return ex_result;
    if (mem_wr_en && mem_wr_addr == src) return mem_result;
    return regs[src];
  endfunction

  function automatic bit model_hazard();
    return in_valid && ex_wr_en && ex_is_load &&
           ((in_uses_rs && ex_wr_addr == in_rs) || (in_uses_rt && ex_wr_addr == in_rt));
  endfunction

  function automatic bit model_ready();
    return (!m_valid || out_ready) && !model_hazard() && !flush;
  endfunction

  // one clock: compare everything at the negedge, advance the model, then return after the posedge
  task automatic tick();
    bit hz, adv, rdy;
    @(negedge clk);
    if (!reset_n) begin
      m_valid = 1'b0; m_stall = 1'b0; m_cnt = 0;
      m_a = '0; m_b = '0; m_imm = '0; m_rd = '0; m_ctrl = '0;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_cnt", 32'(stall_cnt), 32'd0);
    end else begin
      hz  = model_hazard();
      adv = !m_valid || out_ready;
      rdy = model_ready();
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("rf_addr1", 32'(rf_addr1), 32'(in_rs));
      chk("rf_addr2", 32'(rf_addr2), 32'(in_rt));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_a", 32'(out_a), 32'(m_a));
      chk("out_b", 32'(out_b), 32'(m_b));
      chk("out_imm", 32'(out_imm), 32'(m_imm));
      chk("out_rd", 32'(out_rd), 32'(m_rd));
      chk("out_ctrl", 32'(out_ctrl), 32'(m_ctrl));
      chk("stall_active", 32'(stall_active), 32'(m_stall));
      chk("stall_cnt", 32'(stall_cnt), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      chk("sat_cnt", 32'(s_stall_cnt), (m_cnt > 7) ? 32'd7 : 32'(m_cnt));
      if (m_stall) m_cnt++;
      if (flush) m_valid = 1'b0;
      else if (in_valid && rdy) begin
        m_valid = 1'b1;
        m_a = operand(in_rs); m_b = operand(in_rt);
        m_imm = in_imm; m_rd = in_rd; m_ctrl = in_ctrl;
      end else if (adv) m_valid = 1'b0;
      m_stall = hz && !flush;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_uses_rs = 1'b1; in_uses_rt = 1'b1;
    in_rs = 2'd1; in_rt = 2'd2; in_rd = 2'd3; in_imm = 16'h0000; in_ctrl = 8'h00;
    ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_addr = 2'd0; ex_result = 16'h0000;
    mem_wr_en = 1'b0; mem_wr_addr = 2'd0; mem_result = 16'h0000;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    idle_inputs();
    regs[0] = 16'h0000; regs[1] = 16'h1234; regs[2] = 16'h00FF; regs[3] = 16'hC0DE;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // RF path
    in_valid = 1'b1; in_imm = 16'hFFF0; in_ctrl = 8'h3C;
    tick();
    chk("rf_a", 32'(out_a), 32'h1234);
    chk("rf_b", 32'(out_b), 32'h00FF);
    chk("rf_valid", 32'(out_valid), 32'd1);

    // EX over MEM priority, then MEM alone
    ex_wr_en = 1'b1; ex_wr_addr = 2'd1; ex_result = 16'hAAAA;
    mem_wr_en = 1'b1; mem_wr_addr = 2'd1; mem_result = 16'hBBBB;
    tick();
    chk("prio_ex", 32'(out_a), 32'hAAAA);
    ex_wr_en = 1'b0;
    tick();
    chk("prio_mem", 32'(out_a), 32'hBBBB);

    // load-use on rt for one cycle, then MEM forward
    mem_wr_en = 1'b0;
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 2'd2; ex_result = 16'hDEAD;
    #1 chk("lu_ready", 32'(in_ready), 32'd0);
    tick();
    chk("lu_bubble", 32'(out_valid), 32'd0);
    chk("lu_stall", 32'(stall_active), 32'd1);
    ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_wr_en = 1'b1; mem_wr_addr = 2'd2; mem_result = 16'h5A5A;
    tick();
    chk("lu_memfwd", 32'(out_b), 32'h5A5A);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);

    // backpressure
    mem_wr_en = 1'b0;
    tick();
    chk("bp_pre", 32'(out_a), 32'h1234);
    out_ready = 1'b0; regs[1] = 16'h9999;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_hold_a", 32'(out_a), 32'h1234);
      chk("bp_hold_v", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", 32'(in_ready), 32'd1);
    tick();
    chk("bp_new_a", 32'(out_a), 32'h9999);

    // flush during STALL
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 2'd1;
    tick();
    chk("fl_stall", 32'(stall_active), 32'd1);
    flush = 1'b1;
    tick();
    chk("fl_run", 32'(stall_active), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;

    // long stall saturates the narrow counter; uses_rs=0 masks a matching rs
    in_uses_rs = 1'b0; ex_wr_addr = 2'd2;
    for (int i = 0; i < 12; i++) tick();
    chk("sat_narrow", 32'(s_stall_cnt), 32'd7);
    in_uses_rt = 1'b0; in_rs = 2'd2; in_uses_rs = 1'b0;
    #1 chk("mask_ready", 32'(in_ready), 32'd1);
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_rs       = 2'($urandom); in_rt = 2'($urandom); in_rd = 2'($urandom);
      in_uses_rs  = 1'($urandom); in_uses_rt = 1'($urandom);
      in_imm      = 16'($urandom); in_ctrl = 8'($urandom);
      ex_wr_en    = 1'($urandom); ex_is_load = ($urandom_range(0, 2) == 0);
      ex_wr_addr  = 2'($urandom); ex_result = 16'($urandom);
      mem_wr_en   = 1'($urandom); mem_wr_addr = 2'($urandom); mem_result = 16'($urandom);
      flush       = ($urandom_range(0, 9) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      regs[$urandom_range(0, 3)] = 16'($urandom);
      tick();
    end

    // async reset while a transfer is in flight
    idle_inputs();
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 2'd1;
    tick(); tick();
    ex_wr_en = 1'b0; ex_is_load = 1'b0; in_valid = 1'b1;
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_cnt", 32'(stall_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
